// File: rtl/return_timer.sv
`default_nettype none
// ============================================================================
// Module      : return_timer
// Description : Inactivity timer for a vending machine. It reloads on coin or
//               selection activity, counts down in prescaled ticks and raises
//               timeout to request a change return. Optional warning output is
//               enabled by defining RETURN_TIMER_WARN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module return_timer #(
  parameter int WAIT_TIME = 100,
  parameter int TICK_DIV  = 1,
  parameter int WARN_TIME = 10,
  parameter int TOTAL_W   = 32,
  parameter int N_COINS   = 3,
  parameter int N_ITEMS   = 4,
  localparam int CNT_W    = $clog2(WAIT_TIME + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [TOTAL_W-1:0] current_total,
  input  logic [N_COINS-1:0] coin_input,
  input  logic [N_ITEMS-1:0] selection_input,
  input  logic               trigger_return,
  input  logic               return_done,
  output logic               timeout,
  output logic [CNT_W-1:0]   remaining,
  output logic               warning
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_run    = 2'd1;
  localparam logic [1:0] c_st_expire = 2'd2;

  localparam logic [CNT_W-1:0]   c_wait_load = CNT_W'(WAIT_TIME);
  localparam logic [PRESC_W-1:0] c_presc_max = PRESC_W'(TICK_DIV - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [PRESC_W-1:0] presc_q, presc_d;

  logic w_activity;
  logic w_has_credit;
  logic w_tick;

  assign w_activity   = (|coin_input) | (|selection_input);
  assign w_has_credit = |current_total;
  assign w_tick       = (presc_q == c_presc_max);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    case (state_q)
      c_st_idle: begin
        presc_d = '0;
        if (trigger_return && w_has_credit) begin
          state_d = c_st_expire;
        end else if (w_activity) begin
          state_d     = c_st_run;
          remaining_d = c_wait_load;
        end
      end
      c_st_run: begin
        // Return request beats activity, activity beats expiry, expiry beats tick.
        if (trigger_return) begin
          presc_d = '0;
          if (w_has_credit) begin
            state_d = c_st_expire;
          end else begin
            state_d     = c_st_idle;
            remaining_d = '0;
          end
        end else if (w_activity) begin
          remaining_d = c_wait_load;
          presc_d     = '0;
        end else if (remaining_q == '0) begin
          presc_d = '0;
          state_d = w_has_credit ? c_st_expire : c_st_idle;
        end else if (w_tick) begin
          remaining_d = remaining_q - CNT_W'(1);
          presc_d     = '0;
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      c_st_expire: begin
        presc_d = '0;
        if (return_done || !w_has_credit) begin
          state_d     = c_st_idle;
          remaining_d = '0;
        end
      end
      default: begin
        state_d     = c_st_idle;
        remaining_d = '0;
        presc_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= c_st_idle;
      remaining_q <= '0;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
    end
  end

  assign timeout   = (state_q == c_st_expire);
  assign remaining = remaining_q;

`ifdef RETURN_TIMER_WARN_EN
  localparam logic [CNT_W-1:0] c_warn_thr = CNT_W'(WARN_TIME);
  assign warning = (state_q == c_st_run) && (remaining_q != '0) &&
                   (remaining_q <= c_warn_thr);
`else
  assign warning = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_return_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_return_timer
// Description : Directed bench for return_timer with WAIT_TIME=5, WARN_TIME=2,
//               one instance at TICK_DIV=1 and one at TICK_DIV=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_return_timer;

`ifdef RETURN_TIMER_WARN_EN
  localparam bit c_warn_en = 1'b1;
`else
  localparam bit c_warn_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_total;
  logic [2:0]  coin_input;
  logic [3:0]  selection_input;
  logic        trigger_return;
  logic        return_done;

  logic       timeout1, warning1, timeout3, warning3;
  logic [2:0] rem1, rem3;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  return_timer #(
    .WAIT_TIME(5), .TICK_DIV(1), .WARN_TIME(2),
    .TOTAL_W(32), .N_COINS(3), .N_ITEMS(4)
  ) dut (
    .clk(clk), .reset(reset), .current_total(current_total),
    .coin_input(coin_input), .selection_input(selection_input),
    .trigger_return(trigger_return), .return_done(return_done),
    .timeout(timeout1), .remaining(rem1), .warning(warning1)
  );

  return_timer #(
    .WAIT_TIME(5), .TICK_DIV(3), .WARN_TIME(2),
    .TOTAL_W(32), .N_COINS(3), .N_ITEMS(4)
  ) dut3 (
    .clk(clk), .reset(reset), .current_total(current_total),
    .coin_input(coin_input), .selection_input(selection_input),
    .trigger_return(trigger_return), .return_done(return_done),
    .timeout(timeout3), .remaining(rem3), .warning(warning3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    coin_input      = '0;
    selection_input = '0;
    trigger_return  = 1'b0;
    return_done     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    go();
    go();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with every input active
    reset = 1'b1; current_total = 32'd50; coin_input = 3'b111;
    selection_input = 4'b1111; trigger_return = 1'b1; return_done = 1'b1;
    go(); go();
    check("rst_timeout", {31'd0, timeout1}, 32'd0);
    check("rst_remaining", {29'd0, rem1}, 32'd0);
    check("rst_warning", {31'd0, warning1}, 32'd0);
    check("rst_remaining3", {29'd0, rem3}, 32'd0);
    reset = 1'b0; clear_inputs();

    // Basic countdown, expiry and return_done
    current_total = 32'd50;
    coin_input = 3'b001; go(); clear_inputs();
    check("cnt_e0", {29'd0, rem1}, 32'd5);
    for (int e = 1; e <= 5; e++) begin
      go();
      check($sformatf("cnt_e%0d", e), {29'd0, rem1}, 32'(5 - e));
      check($sformatf("cnt_to_e%0d", e), {31'd0, timeout1}, 32'd0);
      check($sformatf("cnt_warn_e%0d", e), {31'd0, warning1},
            32'(c_warn_en && (5 - e) >= 1 && (5 - e) <= 2));
    end
    go();
    check("cnt_to_e6", {31'd0, timeout1}, 32'd1);
    go();
    check("cnt_to_e7", {31'd0, timeout1}, 32'd1);
    return_done = 1'b1; go(); clear_inputs();
    check("done_to_e8", {31'd0, timeout1}, 32'd0);
    check("done_rem_e8", {29'd0, rem1}, 32'd0);

    // Reload from a selection mid-countdown
    do_reset();
    coin_input = 3'b001; go(); clear_inputs();
    go(); go();
    check("rl_rem_e2", {29'd0, rem1}, 32'd3);
    selection_input = 4'b0010; go(); clear_inputs();
    check("rl_rem_e3", {29'd0, rem1}, 32'd5);
    for (int e = 4; e <= 8; e++) go();
    check("rl_rem_e8", {29'd0, rem1}, 32'd0);
    check("rl_to_e8", {31'd0, timeout1}, 32'd0);
    go();
    check("rl_to_e9", {31'd0, timeout1}, 32'd1);

    // Trigger with simultaneous coin, zero balance -> IDLE
    do_reset();
    current_total = 32'd0;
    coin_input = 3'b001; go(); clear_inputs();
    go();
    trigger_return = 1'b1; coin_input = 3'b010; go(); clear_inputs();
    check("trz_to_e2", {31'd0, timeout1}, 32'd0);
    check("trz_rem_e2", {29'd0, rem1}, 32'd0);
    go();
    check("trz_rem_e3", {29'd0, rem1}, 32'd0);

    // Same with credit -> EXPIRE one edge after the request
    do_reset();
    current_total = 32'd30;
    coin_input = 3'b001; go(); clear_inputs();
    go();
    trigger_return = 1'b1; coin_input = 3'b010; go(); clear_inputs();
    check("trc_to_e2", {31'd0, timeout1}, 32'd1);
    coin_input = 3'b100; selection_input = 4'b0001; go(); clear_inputs();
    check("exp_ignore_act", {31'd0, timeout1}, 32'd1);
    current_total = 32'd0; go();
    check("exp_zero_total", {31'd0, timeout1}, 32'd0);

    // Trigger straight from IDLE with credit
    current_total = 32'd30;
    trigger_return = 1'b1; go(); clear_inputs();
    check("idle_trig_to", {31'd0, timeout1}, 32'd1);
    return_done = 1'b1; go(); clear_inputs();
    check("idle_trig_done", {31'd0, timeout1}, 32'd0);

    // Reset in the middle of a countdown
    do_reset();
    current_total = 32'd50;
    coin_input = 3'b001; go(); clear_inputs();
    go(); go();
    reset = 1'b1; go(); reset = 1'b0;
    check("mrst_rem_e3", {29'd0, rem1}, 32'd0);
    check("mrst_to_e3", {31'd0, timeout1}, 32'd0);
    for (int e = 0; e < 10; e++) go();
    check("mrst_to_late", {31'd0, timeout1}, 32'd0);
    check("mrst_rem_late", {29'd0, rem1}, 32'd0);

    // Prescaled countdown on the TICK_DIV=3 instance
    do_reset();
    coin_input = 3'b001; go(); clear_inputs();
    check("div_e0", {29'd0, rem3}, 32'd5);
    for (int e = 1; e <= 15; e++) begin
      go();
      check($sformatf("div_rem_e%0d", e), {29'd0, rem3}, 32'(5 - e / 3));
      check($sformatf("div_warn_e%0d", e), {31'd0, warning3},
            32'(c_warn_en && (5 - e / 3) >= 1 && (5 - e / 3) <= 2));
    end
    check("div_to_e15", {31'd0, timeout3}, 32'd0);
    go(); go();
    check("div_to_e17", {31'd0, timeout3}, 32'd1);
    check("div_warn_e17", {31'd0, warning3}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
